// File: rtl/sim_bus_pkg.sv
// rtl/sim_bus_pkg.sv - shared types and tohost addresses for the simulation bus arbiter
package sim_bus_pkg;

  typedef logic [0:0] id_t;

  localparam id_t MST_CORE    = 1'b0;
  localparam id_t MST_HARNESS = 1'b1;

  localparam logic [31:0] TOHOST_ADDR_A = 32'h8000_1000;
  localparam logic [31:0] TOHOST_ADDR_B = 32'h8000_3000;
  localparam logic [31:0] TOHOST_ADDR_C = 32'h8017_fffc;

  function automatic logic is_tohost_addr(input logic [31:0] addr);
    return (addr == TOHOST_ADDR_A) || (addr == TOHOST_ADDR_B) || (addr == TOHOST_ADDR_C);
  endfunction

endpackage

// File: rtl/sim_bus_id_fifo.sv
// rtl/sim_bus_id_fifo.sv - in-order FIFO of master IDs for outstanding bus transactions
module sim_bus_id_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/sim_bus_arbiter.sv
// rtl/sim_bus_arbiter.sv - two-master round-robin arbiter with in-order response routing
// SIM_ARB_TOHOST_MON_EN adds a monitor that pulses on accepted writes to tohost addresses.
module sim_bus_arbiter
  import sim_bus_pkg::*;
#(
  parameter int OUTSTANDING = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  output logic                m0_gnt,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic                m0_we,
  input  logic [DATA_W/8-1:0] m0_be,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_err,
  input  logic                m1_req,
  output logic                m1_gnt,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic                m1_we,
  input  logic [DATA_W/8-1:0] m1_be,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_err,
  output logic                s_req,
  input  logic                s_gnt,
  output logic [ADDR_W-1:0]   s_addr,
  output logic                s_we,
  output logic [DATA_W/8-1:0] s_be,
  output logic [DATA_W-1:0]   s_wdata,
  input  logic                s_rvalid,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_err,
  output logic                proto_err,
  output logic                tohost_valid,
  output logic [DATA_W-1:0]   tohost_data
);

  id_t  last_q, last_d;
  logic proto_err_q, proto_err_d;
  id_t  sel;
  id_t  head_id;
  logic fifo_full, fifo_empty;
  logic handshake, pop;

  // On a tie the master that did not win last time goes first.
  always_comb begin
    sel = MST_CORE;
    if (m0_req && m1_req) sel = (last_q == MST_CORE) ? MST_HARNESS : MST_CORE;
    else if (m1_req)      sel = MST_HARNESS;
  end

  always_comb begin
    s_addr  = m0_addr;
    s_we    = m0_we;
    s_be    = m0_be;
    s_wdata = m0_wdata;
    if (sel == MST_HARNESS) begin
      s_addr  = m1_addr;
      s_we    = m1_we;
      s_be    = m1_be;
      s_wdata = m1_wdata;
    end
  end

  assign s_req     = (m0_req | m1_req) & ~fifo_full;
  assign handshake = s_req & s_gnt;
  assign m0_gnt    = handshake & (sel == MST_CORE);
  assign m1_gnt    = handshake & (sel == MST_HARNESS);

  assign pop       = s_rvalid & ~fifo_empty;
  assign m0_rvalid = pop & (head_id == MST_CORE);
  assign m1_rvalid = pop & (head_id == MST_HARNESS);
  assign m0_err    = m0_rvalid & s_err;
  assign m1_err    = m1_rvalid & s_err;
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;
  assign proto_err = proto_err_q;

  always_comb begin
    last_d      = handshake ? sel : last_q;
    proto_err_d = proto_err_q | (s_rvalid & fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q      <= MST_HARNESS;
      proto_err_q <= 1'b0;
    end else begin
      last_q      <= last_d;
      proto_err_q <= proto_err_d;
    end
  end

  sim_bus_id_fifo #(
    .DEPTH (OUTSTANDING),
    .WIDTH (1)
  ) u_id_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (handshake),
    .push_data_i (sel),
    .pop_i       (s_rvalid),
    .head_o      (head_id),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

`ifdef SIM_ARB_TOHOST_MON_EN
  logic              tohost_valid_q, tohost_valid_d;
  logic [DATA_W-1:0] tohost_data_q, tohost_data_d;
  logic              tohost_hit;

  assign tohost_hit = handshake & s_we & is_tohost_addr(32'(s_addr));

  always_comb begin
    tohost_valid_d = tohost_hit;
    tohost_data_d  = tohost_hit ? s_wdata : tohost_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tohost_valid_q <= 1'b0;
      tohost_data_q  <= '0;
    end else begin
      tohost_valid_q <= tohost_valid_d;
      tohost_data_q  <= tohost_data_d;
    end
  end

  assign tohost_valid = tohost_valid_q;
  assign tohost_data  = tohost_data_q;
`else
  assign tohost_valid = 1'b0;
  assign tohost_data  = '0;
`endif

endmodule

// File: tb/tb_sim_bus_arbiter.sv
// tb/tb_sim_bus_arbiter.sv - directed self-checking bench with response scoreboard
module tb_sim_bus_arbiter;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } exp_t;

`ifdef SIM_ARB_TOHOST_MON_EN
  localparam logic TH_EN = 1'b1;
`else
  localparam logic TH_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_gnt, m0_we, m0_rvalid, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_be;
  logic        m1_req, m1_gnt, m1_we, m1_rvalid, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_be;
  logic        s_req, s_gnt, s_we, s_rvalid, s_err;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;
  logic        proto_err, tohost_valid;
  logic [31:0] tohost_data;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  logic exp_last;

  always #5 clk = ~clk;

  sim_bus_arbiter #(.OUTSTANDING(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_addr(m0_addr), .m0_we(m0_we), .m0_be(m0_be),
    .m0_wdata(m0_wdata), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_addr(m1_addr), .m1_we(m1_we), .m1_be(m1_be),
    .m1_wdata(m1_wdata), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_req(s_req), .s_gnt(s_gnt), .s_addr(s_addr), .s_we(s_we), .s_be(s_be),
    .s_wdata(s_wdata), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_err(s_err),
    .proto_err(proto_err), .tohost_valid(tohost_valid), .tohost_data(tohost_data)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m1_req = 1'b0;
    s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_err = 1'b0;
  endtask

  task automatic push_exp(input logic id, input logic [31:0] data);
    exp_t e;
    e.id = id;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic drive_resp(input logic err);
    s_rvalid = 1'b1;
    s_err    = err;
    s_rdata  = (sb_q.size() > 0) ? sb_q[0].data : 32'h0;
  endtask

  task automatic check_resp(input string tag, input logic err);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk1({tag, "_sb_nonempty"}, 1'b0, 1'b1);
    end else begin
      e = sb_q.pop_front();
      chk1({tag, "_rvalid_own"}, e.id ? m1_rvalid : m0_rvalid, 1'b1);
      chk1({tag, "_rvalid_other"}, e.id ? m0_rvalid : m1_rvalid, 1'b0);
      chk32({tag, "_rdata"}, e.id ? m1_rdata : m0_rdata, e.data);
      chk1({tag, "_err"}, e.id ? m1_err : m0_err, err);
    end
  endtask

  task automatic check_gnt(input string tag, input logic g0, input logic g1);
    chk1({tag, "_m0_gnt"}, m0_gnt, g0);
    chk1({tag, "_m1_gnt"}, m1_gnt, g1);
  endtask

  task automatic th_write(input string tag, input logic mst, input logic [31:0] addr,
                          input logic [31:0] data, input logic exp_pulse,
                          input logic [31:0] exp_data);
    if (mst) begin
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = addr; m1_wdata = data;
    end else begin
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = addr; m0_wdata = data;
    end
    s_gnt = 1'b1;
    settle();
    check_gnt({tag, "_c0"}, ~mst, mst);
    chk1({tag, "_c0_valid"}, tohost_valid, 1'b0);
    push_exp(mst, 32'h0000_0000);
    exp_last = mst;
    tick();
    m0_req = 1'b0; m1_req = 1'b0; s_gnt = 1'b0;
    drive_resp(1'b0);
    settle();
    check_resp({tag, "_resp"}, 1'b0);
    chk1({tag, "_c1_valid"}, tohost_valid, exp_pulse);
    chk32({tag, "_c1_data"}, tohost_data, exp_data);
    tick();
    s_rvalid = 1'b0;
    settle();
    chk1({tag, "_c2_valid"}, tohost_valid, 1'b0);
    chk32({tag, "_c2_data"}, tohost_data, exp_data);
    tick();
  endtask

  initial begin
    logic exp_sel;
    logic had_resp;

    reset = 1'b1;
    idle_inputs();
    m0_addr = '0; m0_we = 1'b0; m0_be = 4'hf; m0_wdata = '0;
    m1_addr = '0; m1_we = 1'b0; m1_be = 4'h3; m1_wdata = '0;
    exp_last = 1'b1;
    tick();
    tick();
    settle();
    chk1("rst_s_req", s_req, 1'b0);
    check_gnt("rst", 1'b0, 1'b0);
    chk1("rst_m0_rvalid", m0_rvalid, 1'b0);
    chk1("rst_m1_rvalid", m1_rvalid, 1'b0);
    chk1("rst_proto_err", proto_err, 1'b0);
    chk1("rst_tohost_valid", tohost_valid, 1'b0);
    chk32("rst_tohost_data", tohost_data, 32'h0);
    tick();
    reset = 1'b0;

    // single read, response two cycles after the grant
    m0_req = 1'b1; m0_addr = 32'h8000_0000; m0_we = 1'b0; s_gnt = 1'b1;
    settle();
    check_gnt("t1_c0", 1'b1, 1'b0);
    chk1("t1_s_req", s_req, 1'b1);
    chk32("t1_s_addr", s_addr, 32'h8000_0000);
    chk1("t1_s_we", s_we, 1'b0);
    push_exp(1'b0, 32'hDEAD_BEEF);
    exp_last = 1'b0;
    tick();
    m0_req = 1'b0; s_gnt = 1'b0;
    settle();
    chk1("t1_c1_m0_rvalid", m0_rvalid, 1'b0);
    chk1("t1_c1_m1_rvalid", m1_rvalid, 1'b0);
    tick();
    drive_resp(1'b0);
    settle();
    check_resp("t1_c2", 1'b0);
    tick();
    s_rvalid = 1'b0;

    // both masters request every cycle, slave answers one cycle later
    for (int k = 0; k < 6; k++) begin
      m0_req = 1'b1; m1_req = 1'b1; s_gnt = 1'b1;
      m0_addr = 32'h1000_0000 + k; m1_addr = 32'h2000_0000 + k;
      m0_be = 4'hf; m1_be = 4'h3;
      had_resp = (sb_q.size() > 0);
      if (had_resp) drive_resp(1'b0);
      else s_rvalid = 1'b0;
      settle();
      exp_sel = (exp_last == 1'b0) ? 1'b1 : 1'b0;
      check_gnt($sformatf("t2_k%0d", k), ~exp_sel, exp_sel);
      chk32($sformatf("t2_k%0d_s_addr", k), s_addr,
            exp_sel ? 32'h2000_0000 + k : 32'h1000_0000 + k);
      chk32($sformatf("t2_k%0d_s_be", k), {28'h0, s_be}, exp_sel ? 32'h3 : 32'hf);
      if (had_resp) check_resp($sformatf("t2_k%0d", k), 1'b0);
      push_exp(exp_sel, 32'hA5A5_0000 + k);
      exp_last = exp_sel;
      tick();
    end
    m0_req = 1'b0; m1_req = 1'b0; s_gnt = 1'b0;
    drive_resp(1'b0);
    settle();
    check_resp("t2_drain", 1'b0);
    tick();
    s_rvalid = 1'b0;

    // outstanding limit: third request waits for a pop, granted the cycle after
    m0_req = 1'b1; m0_we = 1'b1; m0_wdata = 32'h11; m0_addr = 32'h3000_0000; s_gnt = 1'b1;
    settle();
    check_gnt("t3_a", 1'b1, 1'b0);
    push_exp(1'b0, 32'h3333_0001);
    tick();
    m0_addr = 32'h3000_0004;
    settle();
    check_gnt("t3_b", 1'b1, 1'b0);
    push_exp(1'b0, 32'h3333_0002);
    tick();
    m0_addr = 32'h3000_0008;
    settle();
    chk1("t3_full_s_req", s_req, 1'b0);
    check_gnt("t3_full", 1'b0, 1'b0);
    chk32("t3_full_s_addr", s_addr, 32'h3000_0008);
    tick();
    settle();
    chk1("t3_full2_s_req", s_req, 1'b0);
    tick();
    drive_resp(1'b1);
    settle();
    chk1("t3_pop_s_req", s_req, 1'b0);
    check_gnt("t3_pop", 1'b0, 1'b0);
    check_resp("t3_pop", 1'b1);
    tick();
    s_rvalid = 1'b0; s_err = 1'b0;
    settle();
    chk1("t3_after_s_req", s_req, 1'b1);
    check_gnt("t3_after", 1'b1, 1'b0);
    push_exp(1'b0, 32'h3333_0003);
    exp_last = 1'b0;
    tick();
    m0_req = 1'b0; s_gnt = 1'b0;
    drive_resp(1'b0);
    settle();
    check_resp("t3_d1", 1'b0);
    tick();
    drive_resp(1'b0);
    settle();
    check_resp("t3_d2", 1'b0);
    tick();
    s_rvalid = 1'b0;

    // tohost monitor
    th_write("th_hit", 1'b0, 32'h8000_1000, 32'h1, TH_EN, TH_EN ? 32'h1 : 32'h0);
    th_write("th_miss", 1'b0, 32'h8000_1004, 32'h5, 1'b0, TH_EN ? 32'h1 : 32'h0);
    th_write("th_m1", 1'b1, 32'h8017_fffc, 32'h77, TH_EN, TH_EN ? 32'h77 : 32'h0);

    // response with nothing outstanding
    s_rvalid = 1'b1; s_rdata = 32'h1234;
    settle();
    chk1("pe_m0_rvalid", m0_rvalid, 1'b0);
    chk1("pe_m1_rvalid", m1_rvalid, 1'b0);
    chk1("pe_before", proto_err, 1'b0);
    tick();
    s_rvalid = 1'b0;
    settle();
    chk1("pe_set", proto_err, 1'b1);
    tick();
    tick();
    settle();
    chk1("pe_sticky", proto_err, 1'b1);
    tick();

    // reset with two transactions outstanding and last = m0
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h4000_0000; s_gnt = 1'b1;
    settle();
    check_gnt("rs_a", 1'b1, 1'b0);
    tick();
    settle();
    check_gnt("rs_b", 1'b1, 1'b0);
    tick();
    reset = 1'b1;
    idle_inputs();
    sb_q.delete();
    tick();
    reset = 1'b0;
    settle();
    chk1("rs_proto_err", proto_err, 1'b0);
    chk1("rs_s_req", s_req, 1'b0);
    m0_req = 1'b1; m1_req = 1'b1; s_gnt = 1'b1;
    m0_addr = 32'h5000_0000; m1_addr = 32'h6000_0000;
    settle();
    check_gnt("rs_tie1", 1'b1, 1'b0);
    push_exp(1'b0, 32'hC0DE_0000);
    tick();
    settle();
    check_gnt("rs_tie2", 1'b0, 1'b1);
    push_exp(1'b1, 32'hC0DE_0001);
    tick();
    m0_req = 1'b0; m1_req = 1'b0; s_gnt = 1'b0;
    drive_resp(1'b0);
    settle();
    check_resp("rs_d1", 1'b0);
    tick();
    drive_resp(1'b0);
    settle();
    check_resp("rs_d2", 1'b0);
    tick();
    s_rvalid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sim_bus_arbiter.md
# sim_bus_arbiter

Two-master, one-slave arbiter for the simulation data bus. Shares the simulation slave port (memory plus the UART model at 0x9a10_0000) between the core data port (master 0) and a harness master (master 1: loader or HTIF poke). Uses the req/gnt/rvalid split-transaction protocol. Tracks outstanding transactions so that responses route back in order. Optionally watches accepted writes for tohost traffic.

## Interface
- `OUTSTANDING`, default 2: maximum accepted-but-unanswered transactions (ID FIFO depth, power of two, ≥1).
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; byte enables are `DATA_W/8`.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `m0_req`, `m1_req`  in  1  master request; addr/we/be/wdata held stable until gnt.
- `m0_gnt`, `m1_gnt`  out  1  request accepted this cycle.
- `m0_addr`, `m1_addr`  in  ADDR_W  address.
- `m0_we`, `m1_we`  in  1  write enable.
- `m0_be`, `m1_be`  in  DATA_W/8  byte enables.
- `m0_wdata`, `m1_wdata`  in  DATA_W  write data.
- `m0_rvalid`, `m1_rvalid`  out  1  response valid for that master.
- `m0_rdata`, `m1_rdata`  out  DATA_W  response data (broadcast of `s_rdata`).
- `m0_err`, `m1_err`  out  1  response error (broadcast of `s_err`, qualified by own rvalid).
- `s_req`  out  1  slave request.
- `s_gnt`  in  1  slave accept.
- `s_addr`, `s_we`, `s_be`, `s_wdata`  out  per above  selected master's request fields.
- `s_rvalid`  in  1  slave response valid (in order).
- `s_rdata`  in  DATA_W  slave response data.
- `s_err`  in  1  slave response error.
- `proto_err`  out  1  sticky: `s_rvalid` arrived with no outstanding transaction.
- `tohost_valid`  out  1  tohost write seen (macro-dependent).
- `tohost_data`  out  DATA_W  tohost write data (macro-dependent).

## Operation
- Selection (combinational):
  - Only one master requesting: it is selected.
  - Both requesting: the master not granted last is selected.
  - Round-robin pointer `last` resets to 1, so m0 wins the first tie.
- `s_req = sel_req & !full`. `s_addr`/`s_we`/`s_be`/`s_wdata` mux the selected master's fields, and are driven even while `s_req` = 0.
- `mN_gnt = s_gnt & s_req & (sel == N)`. The unselected master's gnt is 0.
- On handshake (`s_req & s_gnt`):
  - Push sel ID into the ID FIFO.
  - Update `last` to sel.
- On `s_rvalid`:
  - Pop the FIFO head.
  - Assert `mH_rvalid` for head ID H only. `mH_err = s_err`.
  - `rdata` is broadcast to both masters.
- `full` is the registered count == `OUTSTANDING`. A pop in the same cycle does not relieve `full`; the grant waits one cycle.
- Push and pop in the same cycle: count unchanged, head advances, order preserved.
- `s_rvalid` while the FIFO is empty:
  - No master rvalid.
  - `proto_err` set, and held until reset.
- Reset mid-operation clears the FIFO, count, `last`, `proto_err` and tohost state. The slave must be reset in the same cycle.
- No request may be withdrawn before gnt. This is the master's obligation, not checked.

## Timing
- Request path fully combinational: `mN_req` → `s_req` → `s_gnt` → `mN_gnt` in the same cycle. No added request latency.
- Response routing is combinational from the registered FIFO head: `s_rvalid` → `mN_rvalid` in the same cycle.
- Back-to-back grants every cycle while `count < OUTSTANDING`.
- Output reset values:
  - All gnt/rvalid/err = 0 and `s_req` = 0, since the FIFO is empty and no one requests during reset.
  - `proto_err` = 0.
  - `tohost_valid` = 0, `tohost_data` = 0.

## Configuration
- `SIM_ARB_TOHOST_MON_EN` defined:
  - One cycle after an accepted write (`s_req & s_gnt & s_we`) to 0x80001000, 0x80003000 or 0x8017fffc, `tohost_valid` pulses for 1 cycle.
  - `tohost_data` captures `s_wdata` and holds until the next match.
  - Either master's writes qualify.
- Undefined: `tohost_valid` and `tohost_data` tied to 0 and no monitor registers are instantiated.

## Structure
- `sim_bus_pkg`:
  - `id_t` (1-bit master ID), `MST_CORE` = 0, `MST_HARNESS` = 1.
  - The three tohost address constants.
- Sub-module `sim_bus_id_fifo`:
  - Parameterised depth/width.
  - Push/pop/full/empty/head ports and a registered count.
  - Pointer wrap by modulo `OUTSTANDING`.

## Test plan
- m0 read 0x80000000, slave gnt same cycle, rvalid 2 cycles later with rdata 0xDEADBEEF → `m0_gnt`=1 in cycle 0, `m0_rvalid`=1 with 0xDEADBEEF in cycle 2, `m1_rvalid` stays 0.
- Both masters request continuously, `s_gnt`=1, slave answers each transaction 1 cycle later → grants alternate m0,m1,m0,m1 and each rvalid goes to the matching master in order.
- `OUTSTANDING`=2, slave withholds rvalid → third request is not granted (`s_req`=0) until a `s_rvalid` pop. The grant occurs the cycle after the pop.
- `s_rvalid`=1 with no outstanding transaction → no master rvalid and `proto_err`=1 until reset.
- Macro defined, m0 writes 1 to 0x80001000 → `tohost_valid`=1 and `tohost_data`=1 one cycle after gnt. A write to 0x80001004 gives no pulse. Macro undefined: outputs stay 0.
- Reset asserted with 2 transactions outstanding → count 0, `last`=1, `proto_err`=0. The next tie grants m0.
